// File: rtl/apple1_feeder_pkg.sv
// Shared encodings, ASCII constants and the bit-divisor helper for the
// Apple-1 UART feeder.
package apple1_feeder_pkg;

  // Receiver FSM encoding
  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  // Display handshake FSM encoding
  localparam logic [1:0] HS_IDLE    = 2'd0;
  localparam logic [1:0] HS_PRESENT = 2'd1;
  localparam logic [1:0] HS_RELEASE = 2'd2;

  // ASCII constants (CR is the terminal's newline and passes through untouched)
  localparam logic [6:0] CR          = 7'h0D;
  localparam logic [7:0] LF          = 8'h0A;
  localparam logic [7:0] DEL         = 8'h7F;
  localparam logic [6:0] LC_LO       = 7'h61;
  localparam logic [6:0] LC_HI       = 7'h7A;
  localparam logic [6:0] CASE_OFFSET = 7'h20;

  // Clock cycles per serial bit, rounded to nearest
  function automatic int calc_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 serial receiver: input synchroniser, bit divisor, framing FSM.
// Emits a one-cycle byte_valid with data, or a one-cycle frame_err.
module uart_rx
  import apple1_feeder_pkg::*;
#(
  parameter int DIV = 217
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] data,
  output logic       frame_err
);

  localparam int CW   = $clog2(DIV) + 1;
  localparam int HALF = DIV / 2;

  logic          rx_meta;
  logic          rx_s;
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;

  // Two-flop synchroniser; resets to the idle (high) line level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Framing FSM: mid-start check, eight LSB-first data samples, stop check
  // NOTE: every register here is updated with <= so all reads see the
  // pre-edge value; blocking assignments would create ordering hazards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      data       <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        RX_IDLE: begin
          cnt <= '0;
          if (!rx_s) state <= RX_START;
        end
        RX_START: begin
          if (cnt == CW'(HALF - 1)) begin
            cnt <= '0;
            if (!rx_s) begin
              state   <= RX_DATA;
              bit_idx <= '0;
            end else begin
              state <= RX_IDLE;   // too short to be a start bit
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == CW'(DIV - 1)) begin
            cnt     <= '0;
            data    <= {rx_s, data[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= RX_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin // RX_STOP
          if (cnt == CW'(DIV - 1)) begin
            cnt   <= '0;
            state <= RX_IDLE;
            if (rx_s) byte_valid <= 1'b1;
            else      frame_err  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/apple1_uart_feeder.sv
// Serial-to-display feeder for the Apple-1 video terminal: receives host
// bytes, normalises them to the display character set, queues them and
// presents them one at a time with the DA / RDA_n handshake.
module apple1_uart_feeder
  import apple1_feeder_pkg::*;
#(
  parameter int CLK_HZ     = 25_000_000,
  parameter int BAUD       = 115_200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [6:0] rd,
  output logic       da,
  input  logic       rda_n,
  output logic       fifo_full,
  output logic       overrun,
  output logic       frame_err
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic          rx_valid;
  logic [7:0]    rx_data;
  logic [7:0]    stripped;
  logic [6:0]    norm_char;
  logic          norm_keep;
  logic          push_req;
  logic          push;
  logic          pop;
  logic          fifo_empty;
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   wr_next;
  logic [AW:0]   rd_next;
  logic [AW:0]   cnt_next;
  logic [6:0]    mem [FIFO_DEPTH];
  logic          rda_meta;
  logic          rda_s;
  logic [1:0]    hs_state;

  uart_rx #(
    .DIV (calc_div(CLK_HZ, BAUD))
  ) u_rx (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .byte_valid (rx_valid),
    .data       (rx_data),
    .frame_err  (frame_err)
  );

  // Normalise: strip bit 7, fold lowercase to uppercase, drop LF and DEL
  // NOTE: every output of this block gets a value before any condition,
  // so no latch can be inferred.
  always_comb begin
    stripped  = rx_data & 8'h7F;
    norm_char = stripped[6:0];
    if (norm_char >= LC_LO && norm_char <= LC_HI) norm_char = norm_char - CASE_OFFSET;
    norm_keep = (stripped != LF) && (stripped != DEL);
  end

  assign push_req   = rx_valid && norm_keep;
  assign push       = push_req && !fifo_full;
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign pop        = (hs_state == HS_IDLE) && !fifo_empty;
  assign wr_next    = wr_ptr + (AW + 1)'(push);
  assign rd_next    = rd_ptr + (AW + 1)'(pop);
  // Occupancy never exceeds FIFO_DEPTH, so its top bit alone means full
  assign cnt_next   = wr_next - rd_next;

  // FIFO storage
  // NOTE: the data array is deliberately not reset; the pointers alone
  // decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= norm_char;
  end

  // FIFO pointers, registered full flag and overrun pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_full <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      wr_ptr    <= wr_next;
      rd_ptr    <= rd_next;
      fifo_full <= cnt_next[AW];
      overrun   <= push_req && fifo_full;
    end
  end

  // Acknowledge synchroniser; resets to the released (high) level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rda_meta <= 1'b1;
      rda_s    <= 1'b1;
    end else begin
      rda_meta <= rda_n;
      rda_s    <= rda_meta;
    end
  end

  // Handshake: load rd only on IDLE->PRESENT so it stays stable until re-armed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_state <= HS_IDLE;
      rd       <= '0;
      da       <= 1'b0;
    end else begin
      case (hs_state)
        HS_IDLE: begin
          if (!fifo_empty) begin
            rd       <= mem[rd_ptr[AW-1:0]];
            da       <= 1'b1;
            hs_state <= HS_PRESENT;
          end
        end
        HS_PRESENT: begin
          if (!rda_s) begin
            da       <= 1'b0;
            hs_state <= HS_RELEASE;
          end
        end
        default: begin // HS_RELEASE
          if (rda_s) hs_state <= HS_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apple1_uart_feeder.sv
// Directed bench for apple1_uart_feeder with a fast bit rate (DIV = 10).
module tb_apple1_uart_feeder;
  import apple1_feeder_pkg::*;

  localparam int DIV = 10;   // (1_000_000 + 50_000) / 100_000

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic [6:0] rd;
  logic       da;
  logic       rda_n;
  logic       fifo_full;
  logic       overrun;
  logic       frame_err;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int pres_cnt = 0;
  int ovr_cnt = 0;
  int fe_cnt = 0;
  int da_rise_cyc = -1;
  int da_fall_cyc = -1;
  int last_rel_cyc = -1;
  logic da_q = 1'b0;

  apple1_uart_feeder #(
    .CLK_HZ     (1_000_000),
    .BAUD       (100_000),
    .FIFO_DEPTH (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .rd        (rd),
    .da        (da),
    .rda_n     (rda_n),
    .fifo_full (fifo_full),
    .overrun   (overrun),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Event monitor, sampled away from the active edge
  always @(negedge clk) begin
    if (da && !da_q) begin
      pres_cnt++;
      da_rise_cyc = cyc;
    end
    if (!da && da_q) da_fall_cyc = cyc;
    da_q = da;
    if (overrun)   ovr_cnt++;
    if (frame_err) fe_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One 8N1 frame, starting on a falling clock edge
  task automatic send(input logic [7:0] b, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      repeat (DIV) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  task automatic wait_da(input logic val, input int limit, input string tag);
    int n;
    n = 0;
    while (da !== val && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (da !== val) check(tag, {31'd0, da}, {31'd0, val});
  endtask

  // Accept one presented character and complete the handshake
  task automatic ack(input string tag, input logic [6:0] exp);
    wait_da(1'b1, 3000, {tag, "_timeout_da1"});
    check({tag, "_rd"}, {25'd0, rd}, {25'd0, exp});
    repeat (3) @(negedge clk);
    rda_n = 1'b0;
    wait_da(1'b0, 50, {tag, "_timeout_da0"});
    rda_n = 1'b1;
    last_rel_cyc = cyc;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    int t0;
    int t1;
    int p0;
    int fe0;
    int ov0;

    reset = 1'b1;
    rx    = 1'b1;
    rda_n = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_rd",        {25'd0, rd}, 32'd0);
    check("rst_da",        {31'd0, da}, 32'd0);
    check("rst_fifo_full", {31'd0, fifo_full}, 32'd0);
    check("rst_overrun",   {31'd0, overrun}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // 1: single byte, latency and acknowledge timing
    t0 = cyc;
    send(8'h41, 1'b1);
    @(negedge clk);
    check("lat_da_rise", da_rise_cyc, t0 + 100);
    check("lat_rd",      {25'd0, rd}, 32'h41);
    repeat (9) @(negedge clk);
    t1 = cyc;
    rda_n = 1'b0;
    repeat (5) @(negedge clk);
    check("ack_da_fall", da_fall_cyc, t1 + 3);
    check("ack_rd_hold", {25'd0, rd}, 32'h41);
    rda_n = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_da", {31'd0, da}, 32'd0);

    // 2: lowercase fold, LF dropped, bit 7 stripped
    p0 = pres_cnt;
    send(8'h61, 1'b1);
    send(8'h0A, 1'b1);
    send(8'h8D, 1'b1);
    ack("norm_a", 7'h41);
    ack("norm_cr", CR);
    repeat (300) @(negedge clk);
    check("norm_pres", pres_cnt - p0, 32'd2);
    check("norm_ovr",  ovr_cnt, 32'd0);

    // 3: fill, overrun, ordered drain
    for (int i = 0; i < 18; i++) begin
      send(8'h30 + 8'(i), 1'b1);
      @(negedge clk);
      if (i == 15) check("full_at16", {31'd0, fifo_full}, 32'd0);
      if (i == 16) begin
        check("full_at17", {31'd0, fifo_full}, 32'd1);
        check("ovr_at17",  ovr_cnt, 32'd0);
      end
    end
    check("ovr_at18", ovr_cnt, 32'd1);
    ack("drain0", 7'h30);
    check("rel_to_da", da_rise_cyc, last_rel_cyc + 4);
    for (int i = 1; i < 17; i++) ack("drain", 7'h30 + 7'(i));
    repeat (50) @(negedge clk);
    check("drain_empty_da", {31'd0, da}, 32'd0);
    check("drain_not_full", {31'd0, fifo_full}, 32'd0);
    check("drain_ovr",      ovr_cnt, 32'd1);

    // 4: framing error, then recovery
    fe0 = fe_cnt;
    ov0 = ovr_cnt;
    p0  = pres_cnt;
    send(8'h55, 1'b0);
    repeat (3 * DIV) @(negedge clk);
    check("fe_count", fe_cnt - fe0, 32'd1);
    check("fe_nopush", pres_cnt - p0, 32'd0);
    check("fe_no_ovr", ovr_cnt - ov0, 32'd0);
    send(8'h5A, 1'b1);
    ack("fe_recover", 7'h5A);

    // 5: 0.3-bit glitch is rejected
    fe0 = fe_cnt;
    p0  = pres_cnt;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    check("glitch_fe",   fe_cnt - fe0, 32'd0);
    check("glitch_pres", pres_cnt - p0, 32'd0);

    // 6: reset mid-handshake with entries queued
    send(8'h42, 1'b1);
    send(8'h43, 1'b1);
    send(8'h44, 1'b1);
    send(8'h45, 1'b1);
    @(negedge clk);
    check("pre_rst_da", {31'd0, da}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_da",   {31'd0, da}, 32'd0);
    check("rst_mid_full", {31'd0, fifo_full}, 32'd0);
    check("rst_mid_rd",   {25'd0, rd}, 32'd0);
    reset = 1'b0;
    p0 = pres_cnt;
    repeat (300) @(negedge clk);
    check("post_rst_pres", pres_cnt - p0, 32'd0);
    check("post_rst_da",   {31'd0, da}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
